// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: frames are start(0), WIDTH data bits LSB first, stop(1).
// Latency: a write into an empty FIFO on an idle line drives the start bit one edge later.
// Backpressure: ready drops when DEPTH entries are queued; writes while not ready are dropped and latch overflow.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   clock_divider [15:0]  clock cycles per bit (0 behaves as 1), sampled when a start bit begins
//   write_en, data_in     enqueue request and the byte to send
//   tx                    registered serial output, idle high
//   ready                 FIFO not full
//   busy                  frame in flight or FIFO non-empty
//   overflow              sticky, set by a write attempted while ready is low
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      clock_divider,
   input  logic             write_en,
   input  logic [WIDTH-1:0] data_in,
   output logic             tx,
   output logic             ready,
   output logic             busy,
   output logic             overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [15:0]      bit_cnt, cnt_n;
   logic [15:0]      div_q, div_n;
   logic [IW-1:0]    bit_idx, idx_n;
   logic [WIDTH-1:0] shifter, shift_n;
   logic             tx_q, tx_n;
   logic             overflow_q;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;

   logic             full, empty, wr_acc, pop, bit_done;
   logic [15:0]      div_eff;

   // Status flags come only from registered state, never from write_en.
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign ready    = !full;
   assign busy     = (state != IDLE) || !empty;
   assign tx       = tx_q;
   assign overflow = overflow_q;

   // A rejected write (full) never touches the FIFO, even when a pop frees a slot this same edge.
   assign wr_acc   = write_en && !full;
   assign div_eff  = (clock_divider == 16'd0) ? 16'd1 : clock_divider;
   // bit_cnt runs 1..div_q while a level is held; the level changes on the edge where it equals div_q.
   assign bit_done = (bit_cnt == div_q);

   always_comb begin
      state_n = state;
      cnt_n   = bit_cnt;
      div_n   = div_q;
      idx_n   = bit_idx;
      shift_n = shifter;
      tx_n    = tx_q;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               div_n   = div_eff;
               cnt_n   = 16'd1;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_n    = shifter[0];
               shift_n = shifter >> 1;
               idx_n   = '0;
               cnt_n   = 16'd1;
               state_n = DATA;
            end else begin
               cnt_n = bit_cnt + 16'd1;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_n = 16'd1;
               if (bit_idx == LAST_BIT) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  tx_n    = shifter[0];
                  shift_n = shifter >> 1;
                  idx_n   = bit_idx + IW'(1);
               end
            end else begin
               cnt_n = bit_cnt + 16'd1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!empty) begin
                  // Back-to-back: next start bit follows the stop bit with no idle cycle.
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  div_n   = div_eff;
                  cnt_n   = 16'd1;
                  tx_n    = 1'b0;
                  state_n = START;
               end else begin
                  cnt_n   = 16'd0;
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               cnt_n = bit_cnt + 16'd1;
            end
         end
         default: begin
            tx_n    = 1'b1;
            cnt_n   = 16'd0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         div_q   <= 16'd1;
         bit_idx <= '0;
         shifter <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         div_q   <= div_n;
         bit_idx <= idx_n;
         shifter <= shift_n;
         tx_q    <= tx_n;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (write_en && full) overflow_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

endmodule
